// File: rtl/icache_fetch_pkg.sv
// Shared widths, defaults and mem_* bus flag encodings for the instruction cache.
package icache_fetch_pkg;

  localparam int DEF_INDEX_BIT = 6;
  localparam int DEF_WORD_BIT  = 2;
  localparam int ADDR_BUS      = 32;
  localparam int DATA_BUS      = 32;

  localparam logic [1:0] MEM_FLAG_IDLE = 2'b00;
  localparam logic [1:0] MEM_FLAG_READ = 2'b01;

endpackage

// File: rtl/icache_line_store.sv
// Data/tag/valid arrays of the direct-mapped icache: synchronous writes,
// combinational reads, and a single-cycle invalidate of every line.
module icache_line_store
  import icache_fetch_pkg::*;
#(
  parameter int INDEX_BIT = DEF_INDEX_BIT,
  parameter int WORD_BIT  = DEF_WORD_BIT,
  parameter int TAG_BIT   = ADDR_BUS - DEF_INDEX_BIT - DEF_WORD_BIT - 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 invalidate_all,
  input  logic                 tag_we,
  input  logic [INDEX_BIT-1:0] tag_idx,
  input  logic [TAG_BIT-1:0]   tag_in,
  input  logic                 valid_in,
  input  logic                 data_we,
  input  logic [INDEX_BIT-1:0] data_idx,
  input  logic [WORD_BIT-1:0]  data_word,
  input  logic [DATA_BUS-1:0]  data_in,
  input  logic [INDEX_BIT-1:0] rd_idx,
  input  logic [WORD_BIT-1:0]  rd_word,
  output logic [TAG_BIT-1:0]   rd_tag,
  output logic                 rd_valid,
  output logic [DATA_BUS-1:0]  rd_data
);

  localparam int LINES = 1 << INDEX_BIT;
  localparam int WORDS = 1 << (INDEX_BIT + WORD_BIT);

  logic [LINES-1:0]    valid_q;
  logic [TAG_BIT-1:0]  tag_mem  [LINES];
  logic [DATA_BUS-1:0] data_mem [WORDS];

  // invalidate_all wins over a same-cycle tag write so a flush is never lost
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (invalidate_all) begin
      valid_q <= '0;
    end else if (tag_we) begin
      valid_q[tag_idx] <= valid_in;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_mem[tag_idx] <= tag_in;
    end
    if (data_we) begin
      data_mem[{data_idx, data_word}] <= data_in;
    end
  end

  assign rd_tag   = tag_mem[rd_idx];
  assign rd_valid = valid_q[rd_idx];
  assign rd_data  = data_mem[{rd_idx, rd_word}];

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache with sequential line refill over mem_* channel 0.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_fetch
  import icache_fetch_pkg::*;
#(
  parameter int INDEX_BIT = DEF_INDEX_BIT,
  parameter int WORD_BIT  = DEF_WORD_BIT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_req,
  input  logic [ADDR_BUS-1:0] fetch_addr,
  input  logic                flush,
  output logic                fetch_valid,
  output logic [DATA_BUS-1:0] fetch_data,
  output logic [1:0]          mem_rw_flag,
  output logic [ADDR_BUS-1:0] mem_addr,
  input  logic [DATA_BUS-1:0] mem_r_data,
  input  logic                mem_busy,
  input  logic                mem_done,
  output logic [31:0]         stat_hits,
  output logic [31:0]         stat_misses,
  output logic [1:0]          dbg_state
);

  // Handshakes: fetch_req/fetch_addr are held until a one-cycle fetch_valid pulse;
  // a refill read is one flag=01 cycle issued only while !mem_busy, completed by a mem_done pulse.

  localparam int TAG_LSB = INDEX_BIT + WORD_BIT + 2;
  localparam int TAG_BIT = ADDR_BUS - TAG_LSB;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [TAG_BIT-1:0]   f_tag, a_tag_q, rd_tag, tag_wr_tag;
  logic [INDEX_BIT-1:0] f_idx, a_idx_q, tag_wr_idx;
  logic [WORD_BIT-1:0]  f_word, a_word_q, cnt_q;
  logic [DATA_BUS-1:0]  rd_data, crit_q;
  logic                 rd_valid, hit, flush_pend_q;
  logic                 hit_take, miss_start, data_we, tag_we, tag_valid, last_beat;
  logic                 unused_addr_bits;

  assign f_tag            = fetch_addr[ADDR_BUS-1:TAG_LSB];
  assign f_idx            = fetch_addr[TAG_LSB-1:WORD_BIT+2];
  assign f_word           = fetch_addr[WORD_BIT+1:2];
  assign unused_addr_bits = ^fetch_addr[1:0];
  assign hit              = rd_valid && (rd_tag == f_tag);
  assign dbg_state        = state_q;

  icache_line_store #(
    .INDEX_BIT (INDEX_BIT),
    .WORD_BIT  (WORD_BIT),
    .TAG_BIT   (TAG_BIT)
  ) u_store (
    .clk            (clk),
    .rst            (rst),
    .invalidate_all (flush),
    .tag_we         (tag_we),
    .tag_idx        (tag_wr_idx),
    .tag_in         (tag_wr_tag),
    .valid_in       (tag_valid),
    .data_we        (data_we),
    .data_idx       (a_idx_q),
    .data_word      (cnt_q),
    .data_in        (mem_r_data),
    .rd_idx         (f_idx),
    .rd_word        (f_word),
    .rd_tag         (rd_tag),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hit_take    = 1'b0;
    miss_start  = 1'b0;
    data_we     = 1'b0;
    tag_we      = 1'b0;
    tag_valid   = 1'b0;
    last_beat   = 1'b0;
    mem_rw_flag = MEM_FLAG_IDLE;
    mem_addr    = '0;
    tag_wr_idx  = a_idx_q;
    tag_wr_tag  = a_tag_q;
    case (state_q)
      ST_IDLE: begin
        tag_wr_idx = f_idx;
        tag_wr_tag = f_tag;
        if (fetch_req) begin
          if (hit) begin
            hit_take = 1'b1;
          end else begin
            // Drop the victim's valid bit up front: its data is overwritten word by word
            miss_start = 1'b1;
            tag_we     = 1'b1;
            state_d    = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        mem_addr = {a_tag_q, a_idx_q, cnt_q, 2'b00};
        if (!mem_busy) begin
          mem_rw_flag = MEM_FLAG_READ;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_done) begin
          data_we = 1'b1;
          if (cnt_q == '1) begin
            tag_we    = 1'b1;
            tag_valid = !(flush_pend_q || flush);
            last_beat = 1'b1;
            state_d   = ST_RESP;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_tag_q      <= '0;
      a_idx_q      <= '0;
      a_word_q     <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      crit_q       <= '0;
      fetch_valid  <= 1'b0;
      fetch_data   <= '0;
    end else begin
      fetch_valid <= hit_take || last_beat;
      if (miss_start) begin
        a_tag_q      <= f_tag;
        a_idx_q      <= f_idx;
        a_word_q     <= f_word;
        cnt_q        <= '0;
        flush_pend_q <= 1'b0;
      end else if (flush && (state_q == ST_REQ || state_q == ST_WAIT)) begin
        flush_pend_q <= 1'b1;
      end
      if (data_we) begin
        if (cnt_q == a_word_q) begin
          crit_q <= mem_r_data;
        end
        if (cnt_q != '1) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      // The last beat is not yet in the store, so the requested word may come straight off the bus
      if (hit_take) begin
        fetch_data <= rd_data;
      end else if (last_beat) begin
        fetch_data <= (cnt_q == a_word_q) ? mem_r_data : crit_q;
      end
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hits_q, misses_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      if (hit_take && hits_q != 32'hFFFF_FFFF) begin
        hits_q <= hits_q + 32'd1;
      end
      if (miss_start && misses_q != 32'hFFFF_FFFF) begin
        misses_q <= misses_q + 32'd1;
      end
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Directed scoreboard bench for icache_fetch: memory responder, fetch driver, response monitor.
module tb_icache_fetch;
  import icache_fetch_pkg::*;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

`ifdef ICACHE_STATS_EN
  localparam logic [31:0] EXP_HITS   = 32'd1;
  localparam logic [31:0] EXP_MISSES = 32'd1;
`else
  localparam logic [31:0] EXP_HITS   = 32'd0;
  localparam logic [31:0] EXP_MISSES = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        flush = 1'b0;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic [1:0]  mem_rw_flag;
  logic [31:0] mem_addr;
  logic [31:0] mem_r_data = '0;
  logic        mem_busy = 1'b0;
  logic        mem_done = 1'b0;
  logic [31:0] stat_hits, stat_misses;
  logic [1:0]  dbg_state;

  logic [31:0] exp_q[$];
  logic [31:0] rd_log[$];
  int          total = 0;
  int          bad = 0;
  int          spur_cnt = 0;
  int          spur_done = 0;
  logic        pending = 1'b0;
  logic [31:0] pend_addr = '0;

  icache_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .flush       (flush),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .mem_rw_flag (mem_rw_flag),
    .mem_addr    (mem_addr),
    .mem_r_data  (mem_r_data),
    .mem_busy    (mem_busy),
    .mem_done    (mem_done),
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses),
    .dbg_state   (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Memory responder: a read seen at one falling edge completes with mem_done one cycle later.
  // Memory word at address a is 32'hC0DE_0000 | a[15:0].
  always @(negedge clk) begin
    mem_done = 1'b0;
    if (pending) begin
      mem_done   = 1'b1;
      mem_r_data = 32'hC0DE_0000 | {16'h0000, pend_addr[15:0]};
      pending    = 1'b0;
    end else if (spur_done != spur_cnt) begin
      mem_done   = 1'b1;
      mem_r_data = 32'hDEAD_BEEF;
      spur_done++;
    end
    if (mem_rw_flag == MEM_FLAG_READ) begin
      pending   = 1'b1;
      pend_addr = mem_addr;
      rd_log.push_back(mem_addr);
    end
  end

  // Monitor: every fetch_valid pulse consumes one expected word
  always @(negedge clk) begin
    if (rst && fetch_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected fetch_valid: got data %h, required no response", fetch_data);
      end else begin
        chk("fetch_data", fetch_data, exp_q.pop_front());
      end
    end
  end

  // Driver: starts a cycle after posedge+1, holds the request until fetch_valid, checks latency
  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_data,
                       input int exp_lat, input bit with_flush);
    int cyc;
    cyc = 0;
    exp_q.push_back(exp_data);
    fetch_addr = addr;
    fetch_req  = 1'b1;
    if (with_flush) flush = 1'b1;
    do begin
      @(posedge clk);
      #1;
      if (with_flush) flush = 1'b0;
      cyc++;
    end while (!fetch_valid && cyc < 200);
    fetch_req = 1'b0;
    chk("fetch latency", cyc, exp_lat);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reads(input string name, input logic [31:0] base, input int n);
    chk({name, " count"}, rd_log.size(), n);
    for (int i = 0; i < n && i < rd_log.size(); i++) begin
      chk({name, " addr"}, rd_log[i], base + 32'(4 * i));
    end
    rd_log.delete();
  endtask

  task automatic wait_state(input logic [1:0] st);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dbg_state != st && n < 50);
    chk("reach state", dbg_state, st);
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("reset fetch_valid", fetch_valid, 0);
    chk("reset fetch_data", fetch_data, 0);
    chk("reset mem_rw_flag", mem_rw_flag, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset state", dbg_state, S_IDLE);
    chk("reset stat_hits", stat_hits, 0);
    chk("reset stat_misses", stat_misses, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Cold miss, then hit in the same line
    fetch(32'h0000_0104, 32'hC0DE_0104, 9, 1'b0);
    check_reads("t1 reads", 32'h0000_0100, 4);
    fetch(32'h0000_0108, 32'hC0DE_0108, 1, 1'b0);
    check_reads("t2 reads", 32'h0, 0);
    chk("stat_hits", stat_hits, EXP_HITS);
    chk("stat_misses", stat_misses, EXP_MISSES);

    // A stray mem_done in IDLE must not touch the store
    spur_cnt++;
    repeat (3) @(posedge clk);
    #1;
    fetch(32'h0000_010C, 32'hC0DE_010C, 1, 1'b0);
    check_reads("spurious reads", 32'h0, 0);

    // Same index, different tag: both miss
    fetch(32'h0000_0500, 32'hC0DE_0500, 9, 1'b0);
    check_reads("t3a reads", 32'h0000_0500, 4);
    fetch(32'h0000_0100, 32'hC0DE_0100, 9, 1'b0);
    check_reads("t3b reads", 32'h0000_0100, 4);

    // Flush in the same cycle as a hit: hit served, line gone afterwards
    fetch(32'h0000_0104, 32'hC0DE_0104, 1, 1'b1);
    fetch(32'h0000_0100, 32'hC0DE_0100, 9, 1'b0);
    check_reads("flush-hit reads", 32'h0000_0100, 4);

    // Flush during refill: response delivered, line stays invalid
    fork
      fetch(32'h0000_0200, 32'hC0DE_0200, 9, 1'b0);
      begin
        wait_state(S_WAIT);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
    join
    check_reads("t4 reads", 32'h0000_0200, 4);
    fetch(32'h0000_0200, 32'hC0DE_0200, 9, 1'b0);
    check_reads("t4 refetch reads", 32'h0000_0200, 4);
    fetch(32'h0000_0208, 32'hC0DE_0208, 1, 1'b0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    fetch(32'h0000_0104, 32'hC0DE_0104, 9, 1'b0);
    check_reads("t4 idle-flush reads", 32'h0000_0100, 4);
    fetch(32'h0000_0208, 32'hC0DE_0208, 9, 1'b0);
    check_reads("t4 idle-flush reads b", 32'h0000_0200, 4);

    // Busy controller holds the request
    mem_busy = 1'b1;
    fork
      fetch(32'h0000_0300, 32'hC0DE_0300, 19, 1'b0);
      begin
        wait_state(S_REQ);
        for (int i = 0; i < 10; i++) begin
          if (i > 0) @(negedge clk);
          chk("busy flag", {30'd0, mem_rw_flag}, {30'd0, MEM_FLAG_IDLE});
        end
        @(posedge clk);
        #1;
        mem_busy = 1'b0;
        @(negedge clk);
        #1;
        chk("busy release flag", {30'd0, mem_rw_flag}, {30'd0, MEM_FLAG_READ});
        chk("busy release addr", mem_addr, 32'h0000_0300);
      end
    join
    check_reads("t5 reads", 32'h0000_0300, 4);

    // Asynchronous reset mid-refill
    fetch_addr = 32'h0000_0400;
    fetch_req  = 1'b1;
    wait_state(S_WAIT);
    #2;
    rst = 1'b0;
    #1;
    fetch_req = 1'b0;
    chk("rst fetch_valid", fetch_valid, 0);
    chk("rst fetch_data", fetch_data, 0);
    chk("rst mem_rw_flag", mem_rw_flag, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst state", dbg_state, S_IDLE);
    chk("rst stat_hits", stat_hits, 0);
    chk("rst stat_misses", stat_misses, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rd_log.delete();
    fetch(32'h0000_0100, 32'hC0DE_0100, 9, 1'b0);
    check_reads("t6 reads", 32'h0000_0100, 4);

    repeat (2) @(posedge clk);
    chk("responses outstanding", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
